// File: rtl/mux4_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux4_arb_pkg
// Shared definitions for the 4-requester mux arbiter:
//   NREQ / SEL_W   requester count and mux select width
//   state_t        arbiter FSM states (IDLE, GRANT)
//   onehot_to_idx  one-hot grant vector -> requester index
// -----------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // OR-reduction of the set bit positions; exact for one-hot input,
    // returns 0 for an all-zero vector.
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational rotating picker. Scans requesters starting at 'start' and
// wrapping modulo 4; the first request not masked by 'excl' wins.
// Fixed priority 0>1>2>3 is obtained by tying 'start' to 0.
//   req    [3:0]  in   request vector
//   excl   [3:0]  in   requesters that may not win this pick
//   start  [1:0]  in   first index examined
//   found         out  an eligible requester exists
//   idx    [1:0]  out  index of the winner (0 when found is low)
// -----------------------------------------------------------------------------
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  excl,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [NREQ-1:0] eligible;

    assign eligible = req & ~excl;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            // The 2-bit sum wraps naturally, giving the modulo-4 scan order.
            if (!found && eligible[start + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = start + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux4_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_arbiter
// Round-robin arbiter sharing a 4:1 mux among four requesters, with a burst
// limit so no owner holds the mux for more than BURST_MAX cycles while
// another requester waits. All outputs are registered.
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   req   [3:0]  in   per-requester request, held while the mux is needed
//   gnt   [3:0]  out  one-hot grant, zero when idle
//   sel   [1:0]  out  mux select, index of the granted requester
//   valid        out  high while a grant is active
// Parameters:
//   BURST_MAX    max consecutive grant cycles before preemption (1..255)
//   CNT_W        burst counter width, 2**CNT_W > BURST_MAX
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, arbitration uses fixed priority
//                      0>1>2>3 instead of round-robin.
// -----------------------------------------------------------------------------
module mux4_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q,   gnt_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [SEL_W-1:0] pick_start;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] owner;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_start = '0;
`else
    assign pick_start = last_q + SEL_W'(1);
`endif

    // The current owner is always excluded: on preemption that is required,
    // on release its request is already low, and when idle gnt_q is zero.
    rr_pick4 u_pick (
        .req   (req),
        .excl  (gnt_q),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner = onehot_to_idx(gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = CNT_W'(1);
                end
            end

            GRANT: begin
                if (!req[owner] || cnt_q >= CNT_W'(BURST_MAX)) begin
                    // Release, or burst exhausted: hand over if anyone waits.
                    if (pick_found) begin
                        gnt_d   = NREQ'(1) << pick_idx;
                        sel_d   = pick_idx;
                        last_d  = pick_idx;
                        cnt_d   = CNT_W'(1);
                    end else if (!req[owner]) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end
                    // Otherwise the owner keeps the mux with cnt saturated.
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= SEL_W'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_arbiter
// Directed-vector bench for mux4_arbiter with BURST_MAX = 8. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mux4_arbiter;

    localparam int BURST = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;

    int passed;
    int total;

    mux4_arbiter #(
        .BURST_MAX (BURST),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({gnt, sel, valid} !== {4'b0000, 2'd0, 1'b0})
            $display("FAIL reset_state: got gnt=%b sel=%0d valid=%b, want gnt=0000 sel=0 valid=0", gnt, sel, valid);
        else
            passed++;
        for (int n = 1; n <= 5; n++) begin
            tick();
            total++;
            if ({gnt, sel, valid} !== {4'b0000, 2'd0, 1'b0})
                $display("FAIL idle_cyc%0d: got gnt=%b sel=%0d valid=%b, want gnt=0000 sel=0 valid=0", n, gnt, sel, valid);
            else
                passed++;
        end
    endtask

    // Ends idle with sel holding the last granted index.
    task automatic release_all(input string name, input logic [1:0] held_sel);
        req = 4'b0000;
        tick();
        total++;
        if ({gnt, sel, valid} !== {4'b0000, held_sel, 1'b0})
            $display("FAIL %s: got gnt=%b sel=%0d valid=%b, want gnt=0000 sel=%0d valid=0", name, gnt, sel, valid, held_sel);
        else
            passed++;
    endtask

`ifndef ARB_FIXED_PRIO_EN
    // From reset (last=3): 0,1,2,3,0 each for exactly BURST cycles.
    task automatic test_round_robin();
        logic [1:0] o;
        req = 4'b1111;
        for (int n = 1; n <= 5 * BURST; n++) begin
            tick();
            o = 2'((n - 1) / BURST);
            total++;
            if ({gnt, sel, valid} !== {4'b0001 << o, o, 1'b1})
                $display("FAIL rr_cyc%0d: got gnt=%b sel=%0d valid=%b, want gnt=%b sel=%0d valid=1", n, gnt, sel, valid, 4'b0001 << o, o);
            else
                passed++;
        end
        release_all("rr_release", 2'd0);
    endtask
`else
    // Fixed priority: 0 for BURST, 3 for BURST, then 0 again.
    task automatic test_fixed_prio();
        logic [1:0] o;
        req = 4'b1001;
        for (int n = 1; n <= 3 * BURST; n++) begin
            tick();
            o = (((n - 1) / BURST) % 2 == 1) ? 2'd3 : 2'd0;
            total++;
            if ({gnt, sel, valid} !== {4'b0001 << o, o, 1'b1})
                $display("FAIL fp_cyc%0d: got gnt=%b sel=%0d valid=%b, want gnt=%b sel=%0d valid=1", n, gnt, sel, valid, 4'b0001 << o, o);
            else
                passed++;
        end
        release_all("fp_release", 2'd0);
    endtask
`endif

    // Lone requester 2 keeps the grant well past BURST cycles.
    task automatic test_single_saturate();
        req = 4'b0100;
        for (int n = 1; n <= 20; n++) begin
            tick();
            total++;
            if ({gnt, sel, valid} !== {4'b0100, 2'd2, 1'b1})
                $display("FAIL single_cyc%0d: got gnt=%b sel=%0d valid=%b, want gnt=0100 sel=2 valid=1", n, gnt, sel, valid);
            else
                passed++;
        end
        release_all("single_release", 2'd2);
    endtask

    // Owner 1 releases while 3 waits: switch with no bubble.
    task automatic test_release_switch();
        req = 4'b0010;
        tick();
        total++;
        if ({gnt, sel, valid} !== {4'b0010, 2'd1, 1'b1})
            $display("FAIL rel_grant1: got gnt=%b sel=%0d valid=%b, want gnt=0010 sel=1 valid=1", gnt, sel, valid);
        else
            passed++;
        req = 4'b1010;
        for (int n = 1; n <= 3; n++) begin
            tick();
            total++;
            if ({gnt, sel, valid} !== {4'b0010, 2'd1, 1'b1})
                $display("FAIL rel_hold%0d: got gnt=%b sel=%0d valid=%b, want gnt=0010 sel=1 valid=1", n, gnt, sel, valid);
            else
                passed++;
        end
        req = 4'b1000;
        tick();
        total++;
        if ({gnt, sel, valid} !== {4'b1000, 2'd3, 1'b1})
            $display("FAIL rel_switch: got gnt=%b sel=%0d valid=%b, want gnt=1000 sel=3 valid=1", gnt, sel, valid);
        else
            passed++;
        release_all("rel_release", 2'd3);
    endtask

    // Reset mid-grant, then 1 and 3 alternate via burst preemption.
    task automatic test_reset_mid_grant();
        logic [1:0] o;
        do_reset();
        req = 4'b0010;
        tick();
        total++;
        if ({gnt, sel, valid} !== {4'b0010, 2'd1, 1'b1})
            $display("FAIL mid_pre: got gnt=%b sel=%0d valid=%b, want gnt=0010 sel=1 valid=1", gnt, sel, valid);
        else
            passed++;
        rst = 1'b1;
        req = 4'b1010;
        tick();
        total++;
        if ({gnt, sel, valid} !== {4'b0000, 2'd0, 1'b0})
            $display("FAIL mid_reset: got gnt=%b sel=%0d valid=%b, want gnt=0000 sel=0 valid=0", gnt, sel, valid);
        else
            passed++;
        rst = 1'b0;
        for (int n = 1; n <= 3 * BURST; n++) begin
            tick();
            o = (((n - 1) / BURST) % 2 == 1) ? 2'd3 : 2'd1;
            total++;
            if ({gnt, sel, valid} !== {4'b0001 << o, o, 1'b1})
                $display("FAIL post_cyc%0d: got gnt=%b sel=%0d valid=%b, want gnt=%b sel=%0d valid=1", n, gnt, sel, valid, 4'b0001 << o, o);
            else
                passed++;
        end
        release_all("post_release", 2'd1);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        test_reset();
`ifndef ARB_FIXED_PRIO_EN
        test_round_robin();
`else
        test_fixed_prio();
`endif
        test_single_saturate();
        test_release_switch();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter that shares the 4-bit 4:1 selection mux between four requesters. It grants one requester at a time and drives the mux select from that grant. A burst limit keeps any requester from holding the mux indefinitely while others wait. It sits directly in front of the mux: requester i owns mux input ENTi while granted.

## Interface
- BURST_MAX, 8: maximum consecutive granted cycles before a waiting requester may preempt; legal range 1..255
- CNT_W, 8: burst counter width; must satisfy 2^CNT_W > BURST_MAX
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- REQ  input  4  request per requester; held high for as long as the mux is needed
- GNT  output 4  one-hot grant, registered; all zero when idle
- SEL  output 2  mux select, registered; equals index of GNT bit while VALID
- VALID  output 1  registered; high iff a grant is active (GNT != 0)

## Operation
- States: IDLE, GRANT.
- Reset values: state IDLE, GNT=4'b0000, SEL=2'b00, VALID=0, last-grant pointer LAST=3, burst counter CNT=0.
- Arbitration point: picks from REQ, searching LAST+1, LAST+2, LAST+3, LAST (mod 4); the first requester found wins. The winner's index loads SEL and LAST, GNT=one-hot(winner), VALID=1, CNT=1.
- IDLE: if REQ != 0, take an arbitration point and go to GRANT. Otherwise stay; SEL holds its last value.
- GRANT, current owner c:
  - REQ[c]=0 (release): if any other REQ is high, arbitrate and switch with no idle bubble. Otherwise go to IDLE with GNT=0 and VALID=0.
  - REQ[c]=1 and CNT<BURST_MAX: keep the grant, CNT+1.
  - REQ[c]=1, CNT=BURST_MAX, another REQ high: preempt. Arbitrate with c excluded, then switch.
  - REQ[c]=1, CNT=BURST_MAX, no other REQ: keep the grant, CNT saturates at BURST_MAX.
- GNT is always one-hot or zero. SEL never changes while the same grant is held.
- REQ bits of non-owners may toggle freely; they have no effect until the next arbitration point.

## Timing
- Grant latency: 1 cycle. REQ sampled at edge k gives GNT/SEL/VALID valid after edge k.
- Release latency: 1 cycle. The owner dropping REQ before edge k removes or switches the grant at edge k.
- Switch on release or preemption: the new GNT and SEL appear at the same edge the old grant ends; there is no dead cycle.
- Maximum continuous ownership while others wait: BURST_MAX cycles.
- Worst-case wait for a continuously requesting requester: 3*BURST_MAX cycles.
- RST high at any edge, including mid-grant, forces the reset values at that edge and overrides REQ.
- The first arbitration after reset favours requester 0.

## Configuration
- ARB_FIXED_PRIO_EN defined: arbitration points use fixed priority 0>1>2>3. LAST is still updated but is not used for selection. Burst preemption still applies; under it, the owner is excluded and the highest-priority remaining requester wins.
- ARB_FIXED_PRIO_EN undefined: round-robin as described above. This is the default.

## Structure
- Shared package mux4_arb_pkg holds:
  - NREQ=4
  - SEL_W=2
  - the state enum {IDLE, GRANT}
  - the one-hot-to-index conversion function
- Sub-module rr_pick4 is combinational: inputs REQ[3:0], exclude mask[3:0] and start index[1:0]; outputs found and idx[1:0]. Both arbitration modes reuse it; fixed priority uses start index 0 with no rotation.

## Test plan
- Reset, then REQ=4'b0000 for 5 cycles -> GNT=0, VALID=0, SEL=0 throughout.
- REQ=4'b1111 held for 40 cycles, BURST_MAX=8 -> grants 0,1,2,3,0 in turn, each lasting exactly 8 cycles; switches have no bubble; SEL tracks the grant.
- REQ=4'b0100 alone for 20 cycles -> GNT=4'b0100 one cycle later and held; CNT saturates; no drop after cycle 8.
- Owner 1 drops REQ while REQ[3]=1 -> at the next edge GNT=4'b1000, SEL=3, VALID stays 1.
- RST asserted mid-grant (GNT=4'b0010) -> next edge gives GNT=0, VALID=0, SEL=0; with REQ=4'b1010 after reset, requester 1 is granted first.
- ARB_FIXED_PRIO_EN defined, REQ=4'b1001 held -> requester 0 is granted for BURST_MAX cycles, then 3 for BURST_MAX cycles, then back to 0.
